// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered result and zero flag.
// Optional iterative shift-add multiplier, enabled by defining ALU_MUL_EN.
// Without ALU_MUL_EN, code 1000 is treated like any undefined code.
//
// state | meaning
// IDLE  | ready to accept a request
// BUSY  | multiply iterating, one shift-add step per cycle
// DONE  | result held on out/zero until out_ready
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;

    assign accept = in_valid && (state == IDLE);
    assign diff   = A - B;
    assign slt    = $signed(A) < $signed(B);

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             mul_last;

    assign is_mul   = (ALU_control == 4'b1000);
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign mul_last = (state == BUSY) && (cnt == CNT_W'(1));
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle result computed straight from the request; captured at accept.
    always_comb begin
        res      = '0;
        res_zero = 1'b0;
        case (ALU_control)
            4'b0010: res = A + B;
            4'b0110: begin
                res      = diff;
                res_zero = (diff == '0);
            end
            4'b0000: res = A & B;
            4'b0001: res = A | B;
            4'b0111: begin
                res      = {{(WIDTH-1){1'b0}}, slt};
                res_zero = slt;
            end
            4'b0011: res = A ^ B;
            4'b0100: res = A << B[SH_W-1:0];
            4'b0101: res = A >> B[SH_W-1:0];
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = is_mul ? BUSY : DONE;
`ifdef ALU_MUL_EN
            BUSY: if (mul_last) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result and flag registers; written at a single-cycle accept or on the last multiply step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            zero_q <= 1'b0;
        end else if (accept && !is_mul) begin
            out_q  <= res;
            zero_q <= res_zero;
        end
`ifdef ALU_MUL_EN
        else if (mul_last) begin
            out_q  <= acc_next;
            zero_q <= 1'b0;
        end
`endif
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: multiplicand moves left, multiplier right, LSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    assign busy = (state == BUSY);
`else
    assign busy = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = out_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed cases plus random ops against a plain-arithmetic model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALU_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero;
    logic         busy;

    int total  = 0;
    int passed = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: returns {zero, out} from the operation's arithmetic definition.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] c);
        int ua, ub, sa, sb, r, z, sh, m;
        m  = 1 << W;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sh = ub % W;
        r  = 0;
        z  = 0;
        case (c)
            4'd2: r = (ua + ub) % m;
            4'd6: begin r = (ua - ub + m) % m; z = (ua == ub) ? 1 : 0; end
            4'd0: r = ua & ub;
            4'd1: r = ua | ub;
            4'd3: r = ua ^ ub;
            4'd7: begin r = (sa < sb) ? 1 : 0; z = r; end
            4'd4: r = (ua * (1 << sh)) % m;
            4'd5: r = ua / (1 << sh);
            4'd8: r = MUL_EN ? (ua * ub) % m : 0;
            default: r = 0;
        endcase
        return {z[0], r[W-1:0]};
    endfunction

    // One transaction: accept, watch latency/busy, check result, optionally hold DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                          input int hold, input string tag);
        logic [W:0] exp;
        int cyc;
        int exp_lat;
        bit mul;
        exp     = model(a, b, c);
        mul     = MUL_EN && (c == 4'd8);
        exp_lat = mul ? W + 1 : 1;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        A = a; B = b; ALU_control = c; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); ALU_control = 4'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 3 * W) begin
            check({tag, "_busy"}, busy, mul);
            check({tag, "_ready_low"}, in_ready, 0);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_out"}, out, exp[W-1:0]);
        check({tag, "_zero"}, zero, exp[W]);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'b1;
                A = W'($urandom); B = W'($urandom); ALU_control = 4'd2;
                @(negedge clk);
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_ready"}, in_ready, 0);
                check({tag, "_hold_out"}, out, exp[W-1:0]);
                check({tag, "_hold_zero"}, zero, exp[W]);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALU_control = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", out, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;

        run_op(8'd5, 8'd5, 4'b0110, 0, "sub_eq");
        run_op(8'hFF, 8'd1, 4'b0111, 0, "slt_neg");
        run_op(8'd1, 8'hFF, 4'b0111, 0, "slt_pos");
        run_op(8'h81, 8'h09, 4'b0100, 0, "sll");
        run_op(8'h80, 8'd7, 4'b0101, 0, "srl");
        run_op(8'h0F, 8'h11, 4'b1000, 0, "mul");
        run_op(8'hFF, 8'hFF, 4'b1000, 0, "mul_max");
        run_op(8'hFF, 8'h01, 4'b0010, 10, "add_hold");
        run_op(8'd3, 8'd4, 4'b1111, 0, "undef");
        run_op(8'hA5, 8'h3C, 4'b0011, 0, "xor");

        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), 0, "rand");

        // Reset in cycle 4 of a multiply, with a nonzero result left from before.
        run_op(8'h10, 8'h20, 4'b0010, 0, "pre_rst");
        @(negedge clk);
        A = 8'h0F; B = 8'h11; ALU_control = 4'b1000; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out", out, 0);
        check("midrst_zero", zero, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("postrst_in_ready", in_ready, 1);
        run_op(8'd2, 8'd3, 4'b0010, 0, "post_rst_add");

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 64-bit execute-stage ALU: WIDTH-bit operands, same 4-bit control encoding and zero-flag rules, plus XOR, logical shifts and an iterative multiply. Operands are registered at acceptance; the result and zero flag are registered and held until consumed. It sits between decode/register-read and writeback in the sequential core. Single-cycle ops take one cycle; MUL stalls the core through the handshake.

## Interface
Parameters:
- WIDTH, 64, operand/result width; must be a power of two, at least 8.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  request carries a valid operation.
- in_ready  output  1  block accepts a request this cycle; high exactly in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_control  input  4  operation select.
- out_valid  output  1  result held in out/zero.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  registered result.
- zero  output  1  registered branch/compare flag.
- busy  output  1  high in BUSY (MUL iterating).

## Operation
- States: IDLE, BUSY, DONE.
- Accept: in_valid && in_ready at a rising edge. A, B and ALU_control are latched; later input changes are ignored.
- IDLE -> DONE: single-cycle op. out and zero are written at the accept edge.
- IDLE -> BUSY: MUL (1000), only with ALU_MUL_EN. Counter loads WIDTH; accumulator clears.
- BUSY: one shift-add step per cycle (multiplier LSB first). When the counter reaches 0, go to DONE with out = low WIDTH bits of A*B.
- DONE: out_valid=1; out and zero are stable. On out_ready, go to IDLE. No accept in the same cycle, because in_ready=0 in DONE.
- Encodings:
  - 0010 ADD: A+B mod 2^WIDTH.
  - 0110 SUB: A-B mod 2^WIDTH.
  - 0000 AND.
  - 0001 OR.
  - 0111 SLT: signed A<B gives 1, else 0, zero-extended.
  - 0011 XOR.
  - 0100 SLL: A << B[log2(WIDTH)-1:0].
  - 0101 SRL: logical right shift, same shift amount.
  - 1000 MUL.
  - Any other code: out=0, zero=0, single-cycle.
- Shift amount uses only the low log2(WIDTH) bits of B; upper bits are ignored.
- Carry and overflow are discarded; no flags beyond zero.
- zero:
  - SUB: 1 iff A-B == 0.
  - SLT: equals the SLT result bit.
  - All other ops, including MUL: 0.

## Timing
- Reset (asynchronous, at any time, including mid-MUL): state=IDLE, out_valid=0, out=0, zero=0, busy=0, counter=0, accumulator=0. in_ready=1 while reset is held and after release.
- Latency is counted from the accept edge; the first cycle after it is cycle 1.
  - Single-cycle op: out_valid=1 in cycle 1.
  - MUL: busy=1 in cycles 1..WIDTH; out_valid=1 in cycle WIDTH+1.
- Back-to-back single-cycle ops with out_ready tied high: one accept every 2 cycles.
- Back-to-back MUL: one accept every WIDTH+2 cycles.
- out_ready is ignored unless out_valid=1. Holding out_ready low keeps DONE indefinitely with out/zero unchanged.
- in_valid while BUSY/DONE: ignored and not queued. The requester must hold it until it sees in_ready.
- in_ready and busy are decoded from the state register only; no combinational path from in_valid or out_ready.

## Configuration
- ALU_MUL_EN defined: MUL decodes as above; BUSY state, counter and accumulator are present.
- ALU_MUL_EN undefined: 1000 behaves as an undefined code (out=0, zero=0, single-cycle). BUSY is unreachable, busy is tied 0, and the multiplier datapath is not built.

## Test plan
- WIDTH=64, SUB A=5 B=5, out_ready=1 -> out_valid in cycle 1, out=0, zero=1. Then SLT A=-1 B=1 -> out=1, zero=1.
- WIDTH=8, SLL A=0x81 B=0x09 -> out=0x02 (shift 1, B[7:3] ignored). SRL A=0x80 B=7 -> out=0x01, zero=0.
- WIDTH=8, ALU_MUL_EN, MUL A=0x0F B=0x11 -> busy in cycles 1..8, in_ready=0, out_valid in cycle 9, out=0xFF, zero=0.
- out_ready held low 10 cycles after ADD 0xFF+0x01 (WIDTH=8) -> out=0x00, zero=0 stable, in_ready=0 throughout. A new in_valid in that window is not accepted.
- Reset asserted in cycle 4 of an 8-bit MUL -> immediately out_valid=0, busy=0, out=0. in_ready=1 after release; the next ADD 2+3 gives out=5.
- Without ALU_MUL_EN: control 1000, A=3 B=4 -> out_valid in cycle 1, out=0, zero=0, busy never 1. Code 1111 -> same response.
